window_gen_3x3: RTL and testbench
=================================

Name: window_gen_3x3

Overview:
- Upstream neighbour of the 3x3 summation stage.
- Accepts a raster-order pixel stream for one frame.
- Buffers two previous lines and emits every fully-populated 3x3 window (valid convolution, no padding) with its top-left row/col tag and an end-of-frame done flag.
- Output fields map one-to-one onto the summation stage's window, row, col and done inputs, possibly through a per-tap multiply stage.

Parameters:
- N, 16, pixel data width in bits.
- IMG_W, 32, frame width in pixels; legal range 3..32.
- IMG_H, 32, frame height in pixels; legal range 3..32.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; arms capture of a new frame.
- valid_in  input  1  pix_in is valid this cycle.
- pix_in  input  N  pixel, raster order (row 0 col 0 first).
- busy  output  1  high from accepted start until the frame's last window is emitted.
- valid_out  output  1  window outputs valid this cycle.
- dout11..dout33  output  N each  window taps; dout<i><j> = pixel(top+i-1, left+j-1).
- row_out  output  5  window top-left row.
- col_out  output  5  window top-left col.
- done_out  output  1  high with the frame's final window only.

Behaviour:
- Reset and clocking: one clock, rst synchronous active-high. On rst:
  - state to IDLE; counters to 0.
  - busy, valid_out, done_out, row_out, col_out, and all dout to 0.
  - Line-buffer contents are don't-care.
- States:
  - IDLE: start moves the block to FILL and clears in_row/in_col. valid_in is ignored.
  - FILL: rows 0..1. Each accepted pixel is written to the line buffers. No output. Leaves for RUN after pixel (1, IMG_W-1).
  - RUN: rows 2..IMG_H-1. After accepting pixel (IMG_H-1, IMG_W-1), returns to IDLE.
- start is ignored outside IDLE.
- Counters: in_col increments per accepted pixel and wraps IMG_W-1 -> 0, incrementing in_row.
- Line buffers: two IMG_W-deep by N memories (lines r-1 and r-2), read and written at in_col on each accepted pixel.
- Window shift: a 3x3 shift register shifts left one column per accepted pixel. The new right column is {lb2[c], lb1[c], pix_in}.
- Emit condition: accepted pixel (r,c) with r>=2 and c>=2.
- Emit timing: emitted on the NEXT edge (latency 1 cycle from the valid_in cycle):
  - valid_out=1.
  - row_out=r-2, col_out=c-2.
  - dout33=pixel(r,c), dout11=pixel(r-2,c-2).
- Line wrap: the shift register is reloaded across the line boundary. Columns 0..1 of each row never emit.
- Suppressed cycles: on cycles with no emit, valid_out=0 and done_out=0. dout/row_out/col_out hold their last values.
- Frame end: done_out=1 only on the cycle whose window is top-left (IMG_H-3, IMG_W-3). busy drops in that same cycle.
- Gaps: valid_in may deassert arbitrarily. There is no backpressure: the downstream stage is a fixed-latency pipeline.
- Window count: exactly (IMG_H-2)*(IMG_W-2) windows per frame.
- Reset mid-frame: the frame is abandoned and the block returns to IDLE. A new start is required.

Optional Feature:
- Macro: WINGEN_ERR_EN.
- Defined: adds output err (1 bit, reset 0, sticky until rst). err sets when:
  - valid_in=1 in IDLE, or
  - start=1 while busy.
- Undefined: the err port and its logic are absent. These events are silently ignored.

Test Plan:
- Basic 5x5 frame: IMG_W=IMG_H=5, pix = r*5+c, valid_in continuous.
  - First valid_out one cycle after pixel 12: dout11..33 = 0,1,2,5,6,7,10,11,12; row_out=0, col_out=0.
  - 9 windows in total.
  - done_out only with the last window (dout33=24, row_out=2, col_out=2); busy falls in that cycle.
- Same 5x5 frame, valid_in toggling 1/0: identical 9 windows in the same order. valid_out never high two cycles in a row.
- Line wrap: 5x5 frame. No window has col_out>2. The window after (0,2) is (1,0) with dout11=5.
- rst at pixel 15 of frame: the next cycle shows all outputs 0 and busy=0. valid_in without start produces no output. A fresh start and 5x5 frame gives the correct 9 windows.
- start while busy, plus valid_in in IDLE: the frame is unaffected and no output results. With WINGEN_ERR_EN, err=1 and stays 1 until rst.
- 32x32 frame: 900 windows. Last window at row_out=29, col_out=29 with done_out=1. Counters wrap correctly at 5-bit limits.

Source files
------------

// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator: buffers two previous lines of a raster frame and emits every full window.
// Define WINGEN_ERR_EN to add a sticky err output flagging misuse (valid_in while idle, start while busy).
module window_gen_3x3 #(
   parameter int N     = 16,
   parameter int IMG_W = 32,
   parameter int IMG_H = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         valid_in,
   input  logic [N-1:0] pix_in,
   output logic         busy,
   output logic         valid_out,
   output logic [N-1:0] dout11,
   output logic [N-1:0] dout12,
   output logic [N-1:0] dout13,
   output logic [N-1:0] dout21,
   output logic [N-1:0] dout22,
   output logic [N-1:0] dout23,
   output logic [N-1:0] dout31,
   output logic [N-1:0] dout32,
   output logic [N-1:0] dout33,
   output logic [4:0]   row_out,
   output logic [4:0]   col_out,
`ifdef WINGEN_ERR_EN
   output logic         done_out,
   output logic         err
`else
   output logic         done_out
`endif
);

   typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

   localparam int         AW       = $clog2(IMG_W);
   localparam logic [4:0] LAST_COL = 5'(IMG_W - 1);
   localparam logic [4:0] LAST_ROW = 5'(IMG_H - 1);

   state_t       state, state_nxt;
   logic [4:0]   in_row, in_col;
   logic [AW-1:0] lb_addr;
   logic [N-1:0] lb1 [IMG_W];
   logic [N-1:0] lb2 [IMG_W];
   logic [N-1:0] win     [3][3];
   logic [N-1:0] win_nxt [3][3];
   logic         accept, line_end, emit, frame_end;

   assign accept    = valid_in && (state != IDLE);
   assign line_end  = (in_col == LAST_COL);
   assign emit      = accept && (state == RUN) && (in_col >= 5'd2);
   assign frame_end = emit && line_end && (in_row == LAST_ROW);
   assign busy      = (state != IDLE);
   assign lb_addr   = in_col[AW-1:0];

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = FILL;
         FILL:    if (accept && line_end && (in_row == 5'd1)) state_nxt = RUN;
         RUN:     if (frame_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_row <= '0;
         in_col <= '0;
      end else if ((state == IDLE) && start) begin
         in_row <= '0;
         in_col <= '0;
      end else if (accept) begin
         if (line_end) begin
            in_col <= '0;
            in_row <= in_row + 5'd1;
         end else begin
            in_col <= in_col + 5'd1;
         end
      end
   end

   // The incoming right-hand column pairs the two buffered lines with the live pixel.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         win_nxt[i][0] = win[i][1];
         win_nxt[i][1] = win[i][2];
      end
      win_nxt[0][2] = lb2[lb_addr];
      win_nxt[1][2] = lb1[lb_addr];
      win_nxt[2][2] = pix_in;
   end

   // Storage needs no reset: every entry is rewritten before it can reach an emitted window.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1[lb_addr] <= pix_in;
         lb2[lb_addr] <= lb1[lb_addr];
         win          <= win_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_out <= 1'b0;
         done_out  <= 1'b0;
         row_out   <= '0;
         col_out   <= '0;
         dout11    <= '0;
         dout12    <= '0;
         dout13    <= '0;
         dout21    <= '0;
         dout22    <= '0;
         dout23    <= '0;
         dout31    <= '0;
         dout32    <= '0;
         dout33    <= '0;
      end else begin
         valid_out <= emit;
         done_out  <= frame_end;
         if (emit) begin
            dout11  <= win_nxt[0][0];
            dout12  <= win_nxt[0][1];
            dout13  <= win_nxt[0][2];
            dout21  <= win_nxt[1][0];
            dout22  <= win_nxt[1][1];
            dout23  <= win_nxt[1][2];
            dout31  <= win_nxt[2][0];
            dout32  <= win_nxt[2][1];
            dout33  <= win_nxt[2][2];
            row_out <= in_row - 5'd2;
            col_out <= in_col - 5'd2;
         end
      end
   end

`ifdef WINGEN_ERR_EN
   always_ff @(posedge clk) begin
      if (rst)
         err <= 1'b0;
      else if (((state == IDLE) && valid_in) || (start && busy))
         err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3: a 5x5 and a 32x32 instance checked every cycle against an image-based model.
// Build with WINGEN_ERR_EN defined to also check the sticky err output.
module tb_window_gen_3x3;

   localparam int N = 16;

   typedef struct packed {
      logic [8:0][N-1:0] taps;
      logic [4:0]        row;
      logic [4:0]        col;
      logic              done;
      logic              busy;
   } win_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   rst;
   logic [1:0]             start, valid_in;
   logic [1:0][N-1:0]      pix_in;
   logic [1:0]             busy, valid_out, done_out;
   logic [1:0][8:0][N-1:0] dout;
   logic [1:0][4:0]        row_out, col_out;
`ifdef WINGEN_ERR_EN
   logic [1:0]             err;
   logic [1:0]             exp_err;
`endif

   logic [N-1:0] img [2][32][32];
   logic [1:0]   drv_emit, drv_done;
   int           drv_r [2];
   int           drv_c [2];

   logic [1:0]       exp_valid, exp_done, exp_busy;
   logic [N-1:0]     exp_taps [2][9];
   logic [1:0][4:0]  exp_row, exp_col;

   int   n_checks = 0;
   int   n_errors = 0;
   bit   checking = 1'b0;
   int   win_cnt [2];
   int   b2b = 0;
   win_t wlog[$];
   win_t last_win [2];
   logic prev_v0 = 1'b0;

   window_gen_3x3 #(.N(N), .IMG_W(5), .IMG_H(5)) dut5 (
      .clk(clk), .rst(rst), .start(start[0]), .valid_in(valid_in[0]), .pix_in(pix_in[0]),
      .busy(busy[0]), .valid_out(valid_out[0]),
      .dout11(dout[0][0]), .dout12(dout[0][1]), .dout13(dout[0][2]),
      .dout21(dout[0][3]), .dout22(dout[0][4]), .dout23(dout[0][5]),
      .dout31(dout[0][6]), .dout32(dout[0][7]), .dout33(dout[0][8]),
      .row_out(row_out[0]), .col_out(col_out[0]),
      .done_out(done_out[0])
`ifdef WINGEN_ERR_EN
      , .err(err[0])
`endif
   );

   window_gen_3x3 #(.N(N), .IMG_W(32), .IMG_H(32)) dut32 (
      .clk(clk), .rst(rst), .start(start[1]), .valid_in(valid_in[1]), .pix_in(pix_in[1]),
      .busy(busy[1]), .valid_out(valid_out[1]),
      .dout11(dout[1][0]), .dout12(dout[1][1]), .dout13(dout[1][2]),
      .dout21(dout[1][3]), .dout22(dout[1][4]), .dout23(dout[1][5]),
      .dout31(dout[1][6]), .dout32(dout[1][7]), .dout33(dout[1][8]),
      .row_out(row_out[1]), .col_out(col_out[1]),
      .done_out(done_out[1])
`ifdef WINGEN_ERR_EN
      , .err(err[1])
`endif
   );

   function automatic int dim(input int d);
      return (d == 0) ? 5 : 32;
   endfunction

   function automatic void check_output(input string name, input int d, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("[TB] FAIL %s dut%0d: got %0d, expected %0d at %0t", name, d, act, expv, $time);
      end
   endfunction

   // Model: a window is due one cycle after an armed pixel with r>=2 and c>=2; taps come straight from the image.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            exp_valid[d] <= 1'b0;
            exp_done[d]  <= 1'b0;
            exp_busy[d]  <= 1'b0;
            exp_row[d]   <= '0;
            exp_col[d]   <= '0;
            for (int k = 0; k < 9; k++) exp_taps[d][k] <= '0;
`ifdef WINGEN_ERR_EN
            exp_err[d]   <= 1'b0;
`endif
         end else begin
            exp_valid[d] <= drv_emit[d];
            exp_done[d]  <= drv_done[d];
            if (drv_emit[d]) begin
               for (int i = 0; i < 3; i++)
                  for (int j = 0; j < 3; j++)
                     exp_taps[d][i*3+j] <= img[d][drv_r[d]-2+i][drv_c[d]-2+j];
               exp_row[d] <= 5'(drv_r[d] - 2);
               exp_col[d] <= 5'(drv_c[d] - 2);
            end
            if (start[d] && !exp_busy[d])
               exp_busy[d] <= 1'b1;
            else if (drv_done[d])
               exp_busy[d] <= 1'b0;
`ifdef WINGEN_ERR_EN
            if ((valid_in[d] && !exp_busy[d]) || (start[d] && exp_busy[d]))
               exp_err[d] <= 1'b1;
`endif
         end
      end
   end

   always @(negedge clk) begin
      win_t wv;
      if (checking) begin
         for (int d = 0; d < 2; d++) begin
            check_output("valid_out", d, 32'(valid_out[d]), 32'(exp_valid[d]));
            check_output("done_out", d, 32'(done_out[d]), 32'(exp_done[d]));
            check_output("busy", d, 32'(busy[d]), 32'(exp_busy[d]));
            check_output("row_out", d, 32'(row_out[d]), 32'(exp_row[d]));
            check_output("col_out", d, 32'(col_out[d]), 32'(exp_col[d]));
            for (int k = 0; k < 9; k++)
               check_output($sformatf("dout%0d%0d", k / 3 + 1, k % 3 + 1), d, 32'(dout[d][k]), 32'(exp_taps[d][k]));
`ifdef WINGEN_ERR_EN
            check_output("err", d, 32'(err[d]), 32'(exp_err[d]));
`endif
            if (valid_out[d] === 1'b1) begin
               wv.taps = dout[d];
               wv.row  = row_out[d];
               wv.col  = col_out[d];
               wv.done = done_out[d];
               wv.busy = busy[d];
               win_cnt[d]++;
               last_win[d] = wv;
               if (d == 0) wlog.push_back(wv);
            end
         end
         if (valid_out[0] === 1'b1 && prev_v0) b2b++;
         prev_v0 = (valid_out[0] === 1'b1);
      end
   end

   task automatic apply_stimulus(input int d, input logic st, input logic vin, input int r, input int c, input logic armed);
      @(posedge clk);
      #1;
      start[d]    = st;
      valid_in[d] = vin;
      pix_in[d]   = vin ? img[d][r][c] : N'($urandom);
      drv_emit[d] = vin && armed && (r >= 2) && (c >= 2);
      drv_done[d] = drv_emit[d] && (r == dim(d) - 1) && (c == dim(d) - 1);
      drv_r[d]    = r;
      drv_c[d]    = c;
   endtask

   task automatic idle(input int d, input int n);
      for (int i = 0; i < n; i++) apply_stimulus(d, 1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic fill_img(input int d, input int base);
      for (int r = 0; r < 32; r++)
         for (int c = 0; c < 32; c++)
            img[d][r][c] = N'(base + r * dim(d) + c);
   endtask

   task automatic run_frame(input int d, input bit gaps, input int start_at);
      int w;
      w = dim(d);
      apply_stimulus(d, 1'b1, 1'b0, 0, 0, 1'b0);
      for (int r = 0; r < w; r++)
         for (int c = 0; c < w; c++) begin
            apply_stimulus(d, 1'((r * w + c) == start_at), 1'b1, r, c, 1'b1);
            if (gaps) idle(d, 1);
         end
      idle(d, 2);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst      = 1'b1;
      start    = '0;
      valid_in = '0;
      drv_emit = '0;
      drv_done = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int first_exp [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
      int n_done, max_col, cnt;
      rst      = 1'b1;
      start    = '0;
      valid_in = '0;
      pix_in   = '0;
      drv_emit = '0;
      drv_done = '0;
      drv_r    = '{0, 0};
      drv_c    = '{0, 0};
      win_cnt  = '{0, 0};
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b0;
      checking = 1'b1;

      @(negedge clk);
      check_output("reset_busy", 0, 32'(busy[0]), 32'd0);
      check_output("reset_valid", 0, 32'(valid_out[0]), 32'd0);
      check_output("reset_dout33", 0, 32'(dout[0][8]), 32'd0);

      // Basic 5x5 frame, continuous valid_in.
      fill_img(0, 0);
      wlog.delete();
      run_frame(0, 1'b0, -1);
      check_output("t1_count", 0, wlog.size(), 32'd9);
      if (wlog.size() >= 9) begin
         for (int k = 0; k < 9; k++)
            check_output($sformatf("t1_first_tap%0d", k), 0, 32'(wlog[0].taps[k]), 32'(first_exp[k]));
         check_output("t1_first_row", 0, 32'(wlog[0].row), 32'd0);
         check_output("t1_first_col", 0, 32'(wlog[0].col), 32'd0);
         check_output("t1_wrap_dout11", 0, 32'(wlog[3].taps[0]), 32'd5);
         check_output("t1_wrap_row", 0, 32'(wlog[3].row), 32'd1);
         check_output("t1_wrap_col", 0, 32'(wlog[3].col), 32'd0);
         check_output("t1_last_dout33", 0, 32'(wlog[8].taps[8]), 32'd24);
         check_output("t1_last_row", 0, 32'(wlog[8].row), 32'd2);
         check_output("t1_last_col", 0, 32'(wlog[8].col), 32'd2);
         check_output("t1_last_done", 0, 32'(wlog[8].done), 32'd1);
         check_output("t1_last_busy", 0, 32'(wlog[8].busy), 32'd0);
         check_output("t1_prev_busy", 0, 32'(wlog[7].busy), 32'd1);
      end
      n_done  = 0;
      max_col = 0;
      foreach (wlog[i]) begin
         if (wlog[i].done) n_done++;
         if (int'(wlog[i].col) > max_col) max_col = int'(wlog[i].col);
      end
      check_output("t1_done_count", 0, n_done, 32'd1);
      check_output("t1_max_col", 0, max_col, 32'd2);

      // Same frame with valid_in toggling.
      b2b = 0;
      wlog.delete();
      run_frame(0, 1'b1, -1);
      check_output("t2_count", 0, wlog.size(), 32'd9);
      check_output("t2_back_to_back", 0, b2b, 32'd0);
      if (wlog.size() >= 9) begin
         check_output("t2_first_dout33", 0, 32'(wlog[0].taps[8]), 32'd12);
         check_output("t2_last_dout33", 0, 32'(wlog[8].taps[8]), 32'd24);
      end

      // valid_in while idle produces nothing.
      cnt = win_cnt[0];
      for (int i = 0; i < 4; i++) apply_stimulus(0, 1'b0, 1'b1, 0, i, 1'b0);
      idle(0, 2);
      @(negedge clk);
      check_output("t3_idle_count", 0, win_cnt[0], cnt);
`ifdef WINGEN_ERR_EN
      check_output("t3_err", 0, 32'(err[0]), 32'd1);
`endif

      // Reset in place of pixel 15, then a fresh frame with a new image.
      fill_img(0, 100);
      apply_stimulus(0, 1'b1, 1'b0, 0, 0, 1'b0);
      for (int p = 0; p < 15; p++) apply_stimulus(0, 1'b0, 1'b1, p / 5, p % 5, 1'b1);
      do_reset();
      @(negedge clk);
      check_output("t4_busy", 0, 32'(busy[0]), 32'd0);
      check_output("t4_valid", 0, 32'(valid_out[0]), 32'd0);
      check_output("t4_dout11", 0, 32'(dout[0][0]), 32'd0);
      check_output("t4_dout33", 0, 32'(dout[0][8]), 32'd0);
      check_output("t4_row", 0, 32'(row_out[0]), 32'd0);
      check_output("t4_col", 0, 32'(col_out[0]), 32'd0);
`ifdef WINGEN_ERR_EN
      check_output("t4_err_cleared", 0, 32'(err[0]), 32'd0);
`endif
      cnt = win_cnt[0];
      for (int p = 15; p < 25; p++) apply_stimulus(0, 1'b0, 1'b1, p / 5, p % 5, 1'b0);
      idle(0, 2);
      @(negedge clk);
      check_output("t4_nostart_count", 0, win_cnt[0], cnt);
      wlog.delete();
      run_frame(0, 1'b0, -1);
      check_output("t4_count", 0, wlog.size(), 32'd9);
      if (wlog.size() >= 9) begin
         check_output("t4_first_dout11", 0, 32'(wlog[0].taps[0]), 32'd100);
         check_output("t4_first_dout33", 0, 32'(wlog[0].taps[8]), 32'd112);
         check_output("t4_last_dout33", 0, 32'(wlog[8].taps[8]), 32'd124);
      end

      // start pulsed mid-frame is ignored.
      do_reset();
      wlog.delete();
      run_frame(0, 1'b0, 7);
      @(negedge clk);
      check_output("t5_count", 0, wlog.size(), 32'd9);
      if (wlog.size() >= 9)
         check_output("t5_last_dout33", 0, 32'(wlog[8].taps[8]), 32'd124);
`ifdef WINGEN_ERR_EN
      check_output("t5_err", 0, 32'(err[0]), 32'd1);
`endif

      // Full-size 32x32 frame.
      fill_img(1, 0);
      cnt = win_cnt[1];
      run_frame(1, 1'b0, -1);
      @(negedge clk);
      check_output("t6_count", 1, win_cnt[1] - cnt, 32'd900);
      check_output("t6_last_row", 1, 32'(last_win[1].row), 32'd29);
      check_output("t6_last_col", 1, 32'(last_win[1].col), 32'd29);
      check_output("t6_last_done", 1, 32'(last_win[1].done), 32'd1);
      check_output("t6_last_dout11", 1, 32'(last_win[1].taps[0]), 32'd957);
      check_output("t6_last_dout33", 1, 32'(last_win[1].taps[8]), 32'd1023);
      check_output("t6_busy", 1, 32'(busy[1]), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
